spm_checker: RTL and testbench

//  Synthesizable scoreboard downstream of the single-port memory stimulus driver.

---
 rtl/spm_checker.sv | 150 +++++++++++++++
 tb/tb_spm_checker.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spm_checker.sv
// rtl/spm_checker.sv - scoreboard snooping a single-port memory bus; shadows writes and checks reads
module spm_checker #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_LATENCY = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clear,
    input  logic                  i_wr_en,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_address,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic                  o_busy,
    output logic [CNT_WIDTH-1:0]  o_wr_cnt,
    output logic [CNT_WIDTH-1:0]  o_rd_cnt,
    output logic [CNT_WIDTH-1:0]  o_uninit_cnt,
    output logic [CNT_WIDTH-1:0]  o_err_cnt,
    output logic                  o_err,
    output logic                  o_proto_err,
    output logic [ADDR_WIDTH-1:0] o_first_err_addr,
    output logic [DATA_WIDTH-1:0] o_first_err_exp,
    output logic [DATA_WIDTH-1:0] o_first_err_act
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int LAST  = READ_LATENCY - 1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic [ADDR_WIDTH-1:0]   ptr_nxt;

    logic [DEPTH-1:0]        valid;
    logic [DATA_WIDTH-1:0]   shadow [DEPTH];

    logic [READ_LATENCY-1:0] pipe_vld;
    logic                    pipe_chk  [READ_LATENCY];
    logic [ADDR_WIDTH-1:0]   pipe_addr [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   pipe_exp  [READ_LATENCY];

    logic run;
    logic do_wr;
    logic do_rd;
    logic proto;
    logic eval;
    logic mism;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign run    = (state == ST_RUN) && !i_clear;
    assign do_wr  = run && i_wr_en && !i_rd_en;
    assign do_rd  = run && i_rd_en && !i_wr_en;
    assign proto  = run && i_wr_en && i_rd_en;
    assign eval   = pipe_vld[LAST] && !i_clear;
    assign mism   = pipe_exp[LAST] != i_rd_data;
    assign o_busy = (state == ST_INIT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_INIT;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        if (i_clear) begin
            state_nxt = ST_INIT;
            ptr_nxt   = '0;
        end else if (state == ST_INIT) begin
            ptr_nxt = ptr + 1'b1;
            if (ptr == {ADDR_WIDTH{1'b1}}) state_nxt = ST_RUN;
        end
    end

    // Shadow storage needs no reset: the INIT sweep invalidates every entry before use.
    always_ff @(posedge i_clk) begin
        if (state == ST_INIT) begin
            valid[ptr] <= 1'b0;
        end else if (do_wr) begin
            valid[i_address]  <= 1'b1;
            shadow[i_address] <= i_wr_data;
        end
        pipe_chk[0]  <= valid[i_address];
        pipe_addr[0] <= i_address;
        pipe_exp[0]  <= shadow[i_address];
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_chk[i]  <= pipe_chk[i-1];
            pipe_addr[i] <= pipe_addr[i-1];
            pipe_exp[i]  <= pipe_exp[i-1];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wr_cnt         <= '0;
            o_rd_cnt         <= '0;
            o_uninit_cnt     <= '0;
            o_err_cnt        <= '0;
            o_err            <= 1'b0;
            o_proto_err      <= 1'b0;
            o_first_err_addr <= '0;
            o_first_err_exp  <= '0;
            o_first_err_act  <= '0;
            pipe_vld         <= '0;
        end else if (i_clear) begin
            o_wr_cnt         <= '0;
            o_rd_cnt         <= '0;
            o_uninit_cnt     <= '0;
            o_err_cnt        <= '0;
            o_err            <= 1'b0;
            o_proto_err      <= 1'b0;
            o_first_err_addr <= '0;
            o_first_err_exp  <= '0;
            o_first_err_act  <= '0;
            pipe_vld         <= '0;
        end else begin
            if (proto) o_proto_err <= 1'b1;
            if (do_wr) o_wr_cnt <= sat_inc(o_wr_cnt);
            if (do_rd) o_rd_cnt <= sat_inc(o_rd_cnt);
            pipe_vld[0] <= do_rd;
            for (int i = 1; i < READ_LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1];
            if (eval) begin
                if (!pipe_chk[LAST]) begin
                    o_uninit_cnt <= sat_inc(o_uninit_cnt);
                end else if (mism) begin
                    o_err_cnt <= sat_inc(o_err_cnt);
                    o_err     <= 1'b1;
                    if (!o_err) begin
                        o_first_err_addr <= pipe_addr[LAST];
                        o_first_err_exp  <= pipe_exp[LAST];
                        o_first_err_act  <= i_rd_data;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spm_checker.sv
// tb/tb_spm_checker.sv - self-checking bench for spm_checker at read latencies 1 and 3
module tb_spm_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] address;
    logic [7:0] wr_data;
    logic [7:0] rdv [2];

    logic        busy    [2];
    logic [15:0] wr_cnt  [2];
    logic [15:0] rd_cnt  [2];
    logic [15:0] un_cnt  [2];
    logic [15:0] err_cnt [2];
    logic        err     [2];
    logic        proto   [2];
    logic [7:0]  fa      [2];
    logic [7:0]  fe      [2];
    logic [7:0]  fx      [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int lat [2];

    bit         cor_en;
    logic [7:0] cor_val;
    logic [7:0] ram  [256];
    logic [7:0] dval [2][8];

    // Reference model: behavioural shadow + time-slotted pending reads
    int          m_init   [2];
    logic [15:0] m_wr     [2];
    logic [15:0] m_rd     [2];
    logic [15:0] m_un     [2];
    logic [15:0] m_ec     [2];
    bit          m_err    [2];
    bit          m_proto  [2];
    logic [7:0]  m_fa     [2];
    logic [7:0]  m_fe     [2];
    logic [7:0]  m_fx     [2];
    bit          m_valid  [2][256];
    logic [7:0]  m_shadow [2][256];
    bit          p_v      [2][8];
    bit          p_chk    [2][8];
    logic [7:0]  p_addr   [2][8];
    logic [7:0]  p_exp    [2][8];

    always #5 clk = ~clk;

    spm_checker #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .READ_LATENCY(1), .CNT_WIDTH(16)) u_lat1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_wr_en(wr_en), .i_rd_en(rd_en),
        .i_address(address), .i_wr_data(wr_data), .i_rd_data(rdv[0]), .o_busy(busy[0]),
        .o_wr_cnt(wr_cnt[0]), .o_rd_cnt(rd_cnt[0]), .o_uninit_cnt(un_cnt[0]), .o_err_cnt(err_cnt[0]),
        .o_err(err[0]), .o_proto_err(proto[0]), .o_first_err_addr(fa[0]), .o_first_err_exp(fe[0]),
        .o_first_err_act(fx[0])
    );

    spm_checker #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .READ_LATENCY(3), .CNT_WIDTH(16)) u_lat3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_wr_en(wr_en), .i_rd_en(rd_en),
        .i_address(address), .i_wr_data(wr_data), .i_rd_data(rdv[1]), .o_busy(busy[1]),
        .o_wr_cnt(wr_cnt[1]), .o_rd_cnt(rd_cnt[1]), .o_uninit_cnt(un_cnt[1]), .o_err_cnt(err_cnt[1]),
        .o_err(err[1]), .o_proto_err(proto[1]), .o_first_err_addr(fa[1]), .o_first_err_exp(fe[1]),
        .o_first_err_act(fx[1])
    );

    function automatic logic [15:0] sat(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic model_reset(input int k);
        m_init[k] = 256;
        m_wr[k] = 0; m_rd[k] = 0; m_un[k] = 0; m_ec[k] = 0;
        m_err[k] = 0; m_proto[k] = 0; m_fa[k] = 0; m_fe[k] = 0; m_fx[k] = 0;
        for (int i = 0; i < 256; i++) m_valid[k][i] = 0;
        for (int s = 0; s < 8; s++) p_v[k][s] = 0;
    endtask

    task automatic model_edge(input int k);
        int s;
        int d;
        s = cyc % 8;
        if (clear) begin
            model_reset(k);
            return;
        end
        if (p_v[k][s]) begin
            p_v[k][s] = 0;
            if (!p_chk[k][s]) begin
                m_un[k] = sat(m_un[k]);
            end else if (p_exp[k][s] !== rdv[k]) begin
                m_ec[k] = sat(m_ec[k]);
                if (!m_err[k]) begin
                    m_fa[k] = p_addr[k][s]; m_fe[k] = p_exp[k][s]; m_fx[k] = rdv[k];
                end
                m_err[k] = 1;
            end
        end
        if (m_init[k] > 0) begin
            m_init[k]--;
            return;
        end
        if (wr_en && rd_en) begin
            m_proto[k] = 1;
        end else if (wr_en) begin
            m_shadow[k][address] = wr_data;
            m_valid[k][address]  = 1;
            m_wr[k] = sat(m_wr[k]);
        end else if (rd_en) begin
            m_rd[k] = sat(m_rd[k]);
            d = (cyc + lat[k]) % 8;
            p_v[k][d] = 1; p_chk[k][d] = m_valid[k][address];
            p_addr[k][d] = address; p_exp[k][d] = m_shadow[k][address];
        end
    endtask

    // Memory being snooped: returns stored data after each checker's latency, optionally corrupted
    task automatic mem_edge();
        if (wr_en) begin
            ram[address] = wr_data;
        end else if (rd_en) begin
            for (int k = 0; k < 2; k++) dval[k][(cyc + lat[k]) % 8] = cor_en ? cor_val : ram[address];
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) for (int k = 0; k < 2; k++) model_edge(k);
        mem_edge();
        cyc++;
        #1;
        for (int k = 0; k < 2; k++) begin
            rdv[k] = dval[k][cyc % 8];
            dval[k][cyc % 8] = 8'($urandom);
        end
    endtask

    task automatic op(input bit w, input bit r, input logic [7:0] a, input logic [7:0] d,
                      input bit ce, input logic [7:0] cv);
        wr_en = w; rd_en = r; address = a; wr_data = d; cor_en = ce; cor_val = cv;
        step();
        wr_en = 0; rd_en = 0; cor_en = 0;
    endtask

    task automatic drain();
        repeat (4) op(0, 0, 8'h00, 8'h00, 0, 8'h00);
    endtask

    task automatic do_clear(output int n);
        clear = 1; wr_en = 0; rd_en = 0;
        step();
        clear = 0;
        n = 0;
        while ((busy[0] || busy[1]) && n < 300) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        rst_n = 0; clear = 0; wr_en = 0; rd_en = 0; address = 0; wr_data = 0; cor_en = 0;
        for (int k = 0; k < 2; k++) model_reset(k);
        repeat (3) step();
        for (int k = 0; k < 2; k++) begin
            checks++; if (busy[k] !== 1'b1) begin errors++; $display("FAIL reset_busy[%0d] got %0b want 1", k, busy[k]); end
            checks++; if ({wr_cnt[k], rd_cnt[k], un_cnt[k], err_cnt[k]} !== 64'd0) begin errors++; $display("FAIL reset_counts[%0d] got %0h want 0", k, {wr_cnt[k], rd_cnt[k], un_cnt[k], err_cnt[k]}); end
            checks++; if ({err[k], proto[k], fa[k], fe[k], fx[k]} !== 26'd0) begin errors++; $display("FAIL reset_flags[%0d] got %0h want 0", k, {err[k], proto[k], fa[k], fe[k], fx[k]}); end
        end
        rst_n = 1;
        n = 0;
        while (busy[0] && n < 400) begin
            step();
            n++;
        end
        checks++; if (n !== 256) begin errors++; $display("FAIL init_sweep_len got %0d want 256", n); end
        checks++; if (busy[1] !== 1'b0) begin errors++; $display("FAIL init_sweep_lat3 busy got %0b want 0", busy[1]); end
        checks++; if (wr_cnt[0] !== 16'd0 || rd_cnt[0] !== 16'd0) begin errors++; $display("FAIL post_init_counts got %0d/%0d want 0/0", wr_cnt[0], rd_cnt[0]); end
    endtask

    task automatic test_basic();
        int n;
        do_clear(n);
        for (int i = 0; i < 4; i++) op(1, 0, 8'(8'h10 + i), 8'(8'h21 + i), 0, 8'h00);
        for (int i = 0; i < 4; i++) op(0, 1, 8'(8'h10 + i), 8'h00, 0, 8'h00);
        drain();
        for (int k = 0; k < 2; k++) begin
            checks++; if (wr_cnt[k] !== 16'd4) begin errors++; $display("FAIL basic_wr_cnt[%0d] got %0d want 4", k, wr_cnt[k]); end
            checks++; if (rd_cnt[k] !== 16'd4) begin errors++; $display("FAIL basic_rd_cnt[%0d] got %0d want 4", k, rd_cnt[k]); end
            checks++; if (err_cnt[k] !== 16'd0 || err[k] !== 1'b0) begin errors++; $display("FAIL basic_err[%0d] got %0d/%0b want 0/0", k, err_cnt[k], err[k]); end
            checks++; if (un_cnt[k] !== 16'd0) begin errors++; $display("FAIL basic_uninit[%0d] got %0d want 0", k, un_cnt[k]); end
        end
    endtask

    task automatic test_mismatch();
        int n;
        do_clear(n);
        for (int i = 0; i < 4; i++) op(1, 0, 8'(8'h10 + i), 8'(8'h21 + i), 0, 8'h00);
        op(0, 1, 8'h10, 8'h00, 0, 8'h00);
        op(0, 1, 8'h11, 8'h00, 0, 8'h00);
        op(0, 1, 8'h12, 8'h00, 1, 8'hFF);
        drain();
        for (int k = 0; k < 2; k++) begin
            checks++; if (err_cnt[k] !== 16'd1 || err[k] !== 1'b1) begin errors++; $display("FAIL mism_err[%0d] got %0d/%0b want 1/1", k, err_cnt[k], err[k]); end
            checks++; if ({fa[k], fe[k], fx[k]} !== 24'h1223FF) begin errors++; $display("FAIL mism_first[%0d] got %06h want 1223ff", k, {fa[k], fe[k], fx[k]}); end
        end
        op(0, 1, 8'h13, 8'h00, 1, 8'h00);
        drain();
        for (int k = 0; k < 2; k++) begin
            checks++; if (err_cnt[k] !== 16'd2) begin errors++; $display("FAIL mism2_err_cnt[%0d] got %0d want 2", k, err_cnt[k]); end
            checks++; if ({fa[k], fe[k], fx[k]} !== 24'h1223FF) begin errors++; $display("FAIL mism2_first[%0d] got %06h want 1223ff", k, {fa[k], fe[k], fx[k]}); end
        end
    endtask

    task automatic test_uninit();
        int n;
        do_clear(n);
        op(0, 1, 8'h80, 8'h00, 1, 8'hA5);
        drain();
        checks++; if (un_cnt[0] !== 16'd1 || err_cnt[0] !== 16'd0) begin errors++; $display("FAIL uninit_read got %0d/%0d want 1/0", un_cnt[0], err_cnt[0]); end
        op(1, 0, 8'h80, 8'h55, 0, 8'h00);
        op(0, 1, 8'h80, 8'h00, 0, 8'h00);
        drain();
        for (int k = 0; k < 2; k++) begin
            checks++; if (un_cnt[k] !== 16'd1 || err_cnt[k] !== 16'd0 || rd_cnt[k] !== 16'd2) begin errors++; $display("FAIL write_then_read[%0d] got un %0d err %0d rd %0d want 1 0 2", k, un_cnt[k], err_cnt[k], rd_cnt[k]); end
        end
    endtask

    task automatic test_proto();
        int n;
        do_clear(n);
        op(1, 1, 8'h05, 8'h77, 0, 8'h00);
        checks++; if (proto[0] !== 1'b1) begin errors++; $display("FAIL proto_flag got %0b want 1", proto[0]); end
        checks++; if (wr_cnt[0] !== 16'd0 || rd_cnt[0] !== 16'd0) begin errors++; $display("FAIL proto_counts got %0d/%0d want 0/0", wr_cnt[0], rd_cnt[0]); end
        op(0, 1, 8'h05, 8'h00, 0, 8'h00);
        drain();
        checks++; if (un_cnt[0] !== 16'd1 || proto[0] !== 1'b1) begin errors++; $display("FAIL proto_unwritten got un %0d proto %0b want 1 1", un_cnt[0], proto[0]); end
    endtask

    task automatic test_clear_inflight();
        int n;
        op(1, 0, 8'h10, 8'h33, 0, 8'h00);
        op(0, 1, 8'h10, 8'h00, 1, 8'hEE);
        do_clear(n);
        checks++; if (n !== 256) begin errors++; $display("FAIL clear_sweep_len got %0d want 256", n); end
        checks++; if ({wr_cnt[1], rd_cnt[1], un_cnt[1], err_cnt[1], 7'(err[1])} !== 71'd0) begin errors++; $display("FAIL clear_discard got %0h want 0", {wr_cnt[1], rd_cnt[1], un_cnt[1], err_cnt[1], err[1]}); end
        op(1, 0, 8'hFF, 8'hFF, 0, 8'h00);
        op(1, 0, 8'h00, 8'h00, 0, 8'h00);
        op(0, 1, 8'hFF, 8'h00, 0, 8'h00);
        op(0, 1, 8'h00, 8'h00, 0, 8'h00);
        drain();
        checks++; if (err_cnt[1] !== 16'd0 || rd_cnt[1] !== 16'd2 || un_cnt[1] !== 16'd0) begin errors++; $display("FAIL boundary got err %0d rd %0d un %0d want 0 2 0", err_cnt[1], rd_cnt[1], un_cnt[1]); end
    endtask

    task automatic test_random();
        int r;
        logic [7:0] a;
        for (int c = 0; c < 600; c++) begin
            r = $urandom_range(0, 99);
            a = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 11));
            op(r < 40 || (r >= 80 && r < 83), r >= 40 && r < 83, a, 8'($urandom),
               $urandom_range(0, 9) == 0, 8'($urandom));
            for (int k = 0; k < 2; k++) begin
                checks++; if (busy[k] !== (m_init[k] > 0)) begin errors++; $display("FAIL rnd_busy[%0d] got %0b want %0b", k, busy[k], m_init[k] > 0); end
                checks++; if (wr_cnt[k] !== m_wr[k]) begin errors++; $display("FAIL rnd_wr_cnt[%0d] got %0d want %0d", k, wr_cnt[k], m_wr[k]); end
                checks++; if (rd_cnt[k] !== m_rd[k]) begin errors++; $display("FAIL rnd_rd_cnt[%0d] got %0d want %0d", k, rd_cnt[k], m_rd[k]); end
                checks++; if (un_cnt[k] !== m_un[k]) begin errors++; $display("FAIL rnd_uninit[%0d] got %0d want %0d", k, un_cnt[k], m_un[k]); end
                checks++; if (err_cnt[k] !== m_ec[k]) begin errors++; $display("FAIL rnd_err_cnt[%0d] got %0d want %0d", k, err_cnt[k], m_ec[k]); end
                checks++; if (err[k] !== m_err[k] || proto[k] !== m_proto[k]) begin errors++; $display("FAIL rnd_flags[%0d] got %0b%0b want %0b%0b", k, err[k], proto[k], m_err[k], m_proto[k]); end
                checks++; if ({fa[k], fe[k], fx[k]} !== {m_fa[k], m_fe[k], m_fx[k]}) begin errors++; $display("FAIL rnd_first[%0d] got %06h want %06h", k, {fa[k], fe[k], fx[k]}, {m_fa[k], m_fe[k], m_fx[k]}); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        op(1, 0, 8'h20, 8'h44, 0, 8'h00);
        op(0, 1, 8'h20, 8'h00, 1, 8'h99);
        #2;
        rst_n = 0;
        for (int k = 0; k < 2; k++) model_reset(k);
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++; if (busy[k] !== 1'b1 || {wr_cnt[k], rd_cnt[k], err[k], proto[k]} !== 34'd0) begin errors++; $display("FAIL midreset[%0d] got busy %0b wr %0d rd %0d want 1 0 0", k, busy[k], wr_cnt[k], rd_cnt[k]); end
        end
        repeat (2) step();
        rst_n = 1;
        n = 0;
        while ((busy[0] || busy[1]) && n < 300) begin
            step();
            n++;
        end
        checks++; if (n !== 256) begin errors++; $display("FAIL midreset_sweep got %0d want 256", n); end
        checks++; if (err_cnt[1] !== 16'd0 || un_cnt[1] !== 16'd0) begin errors++; $display("FAIL midreset_discard got err %0d un %0d want 0 0", err_cnt[1], un_cnt[1]); end
    endtask

    initial begin
        lat[0] = 1;
        lat[1] = 3;
        for (int k = 0; k < 2; k++) begin
            rdv[k] = 8'h00;
            for (int s = 0; s < 8; s++) dval[k][s] = 8'($urandom);
        end
        for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
        test_reset();
        test_basic();
        test_mismatch();
        test_uninit();
        test_proto();
        test_clear_inflight();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
